// File: rtl/game_sequencer.sv
// Round-level controller for the ping-pong game.
// Sequences serve countdown, play and point scoring, and drives the
// paddle/ball datapath controls. Every output is a register.
//
// Handshake note: there is no valid/ready traffic here. Inputs are
// single-cycle pulses (frame_tick, miss_left, miss_right) or a level
// (start_btn) sampled on each rising edge. Outputs paddle_recenter and
// ball_launch are single-cycle pulses aligned with the state they announce.
module game_sequencer #(
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               paddle_recenter,
    output logic               paddle_en,
    output logic               ball_launch,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [7:0]         LP_DELAY = 8'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] LP_WIN   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] w_score1_nxt;
    logic [SCORE_W-1:0] r_score2;
    logic [SCORE_W-1:0] w_score2_nxt;
    logic [1:0]         r_winner;
    logic [1:0]         w_winner_nxt;
    logic               r_serve_dir;
    logic               w_serve_dir_nxt;
    logic               r_recenter;
    logic               w_recenter_nxt;
    logic               r_launch;
    logic               w_launch_nxt;
    logic               r_paddle_en;
    logic               w_paddle_en_nxt;

    // Next-state and next-output decode; everything defaults to hold,
    // pulses default to low.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_score1_nxt    = r_score1;
        w_score2_nxt    = r_score2;
        w_winner_nxt    = r_winner;
        w_serve_dir_nxt = r_serve_dir;
        w_recenter_nxt  = 1'b0;
        w_launch_nxt    = 1'b0;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                // A new game starts from a clean scoreboard and serves left.
                if (start_btn) begin
                    w_score1_nxt    = '0;
                    w_score2_nxt    = '0;
                    w_winner_nxt    = 2'b00;
                    w_serve_dir_nxt = 1'b0;
                    w_cnt_nxt       = LP_DELAY;
                    w_recenter_nxt  = 1'b1;
                    w_state_nxt     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // The tick that lands on the last count launches the ball.
                if (frame_tick) begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                    if (r_cnt == 8'd1) begin
                        w_launch_nxt = 1'b1;
                        w_state_nxt  = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                // The player who missed concedes the point and receives
                // the next serve; a double miss is a let.
                if (miss_left && !miss_right) begin
                    if (r_score2 != LP_WIN) begin
                        w_score2_nxt = r_score2 + 1'b1;
                    end
                    w_serve_dir_nxt = 1'b0;
                end else if (miss_right && !miss_left) begin
                    if (r_score1 != LP_WIN) begin
                        w_score1_nxt = r_score1 + 1'b1;
                    end
                    w_serve_dir_nxt = 1'b1;
                end
                if (miss_left || miss_right) begin
                    w_state_nxt = ST_POINT;
                end
            end
            ST_POINT: begin
                // Scores are already updated here, so the win test is direct.
                if (r_score1 == LP_WIN) begin
                    w_winner_nxt = 2'b01;
                    w_state_nxt  = ST_OVER;
                end else if (r_score2 == LP_WIN) begin
                    w_winner_nxt = 2'b10;
                    w_state_nxt  = ST_OVER;
                end else begin
                    w_recenter_nxt = 1'b1;
                    w_cnt_nxt      = LP_DELAY;
                    w_state_nxt    = ST_SERVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Paddles move only while the ball is in play.
        w_paddle_en_nxt = (w_state_nxt == ST_PLAY);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_score1    <= '0;
            r_score2    <= '0;
            r_winner    <= 2'b00;
            r_serve_dir <= 1'b0;
            r_recenter  <= 1'b0;
            r_launch    <= 1'b0;
            r_paddle_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_score1    <= w_score1_nxt;
            r_score2    <= w_score2_nxt;
            r_winner    <= w_winner_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_recenter  <= w_recenter_nxt;
            r_launch    <= w_launch_nxt;
            r_paddle_en <= w_paddle_en_nxt;
        end
    end

    assign paddle_recenter = r_recenter;
    assign paddle_en       = r_paddle_en;
    assign ball_launch     = r_launch;
    assign serve_dir       = r_serve_dir;
    assign score1          = r_score1;
    assign score2          = r_score2;
    assign winner          = r_winner;
    assign state           = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by
// randomized play, all compared every cycle against a phase-level model.
module tb_game_sequencer;

    localparam int SERVE_DELAY = 3;
    localparam int WIN_SCORE   = 4;
    localparam int SCORE_W     = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               frame_tick = 1'b0;
    logic               start_btn = 1'b0;
    logic               miss_left = 1'b0;
    logic               miss_right = 1'b0;
    logic               paddle_recenter;
    logic               paddle_en;
    logic               ball_launch;
    logic               serve_dir;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [1:0]         winner;
    logic [2:0]         state;

    game_sequencer #(
        .SERVE_DELAY(SERVE_DELAY),
        .WIN_SCORE  (WIN_SCORE),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .miss_left      (miss_left),
        .miss_right     (miss_right),
        .paddle_recenter(paddle_recenter),
        .paddle_en      (paddle_en),
        .ball_launch    (ball_launch),
        .serve_dir      (serve_dir),
        .score1         (score1),
        .score2         (score2),
        .winner         (winner),
        .state          (state)
    );

    // ---------------- reference model ----------------
    // The game is described as a phase plus a scoreboard. A serve is a count
    // of frame ticks seen so far; the ball goes when that count hits the delay.
    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;

    int m_phase;
    int m_ticks_seen;
    int m_p1;
    int m_p2;
    int m_winner;
    int m_dir;
    int m_recenter;
    int m_launch;

    int tests = 0;
    int fails = 0;

    function automatic int sat_inc(input int v);
        return (v + 1 > WIN_SCORE) ? WIN_SCORE : v + 1;
    endfunction

    task automatic model_reset();
        m_phase      = PH_IDLE;
        m_ticks_seen = 0;
        m_p1         = 0;
        m_p2         = 0;
        m_winner     = 0;
        m_dir        = 0;
        m_recenter   = 0;
        m_launch     = 0;
    endtask

    task automatic model_new_game();
        m_p1         = 0;
        m_p2         = 0;
        m_winner     = 0;
        m_dir        = 0;
        m_ticks_seen = 0;
        m_recenter   = 1;
        m_phase      = PH_SERVE;
    endtask

    // One rising edge worth of game rules applied to the sampled inputs.
    task automatic model_edge(input bit st, input bit ft, input bit ml, input bit mr);
        m_recenter = 0;
        m_launch   = 0;
        if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
            if (st) model_new_game();
        end else if (m_phase == PH_SERVE) begin
            if (ft) begin
                m_ticks_seen++;
                if (m_ticks_seen == SERVE_DELAY) begin
                    m_launch = 1;
                    m_phase  = PH_PLAY;
                end
            end
        end else if (m_phase == PH_PLAY) begin
            if (ml || mr) begin
                if (!mr) begin
                    m_p2  = sat_inc(m_p2);
                    m_dir = 0;
                end
                if (!ml) begin
                    m_p1  = sat_inc(m_p1);
                    m_dir = 1;
                end
                m_phase = PH_POINT;
            end
        end else begin
            if (m_p1 == WIN_SCORE) begin
                m_winner = 1;
                m_phase  = PH_OVER;
            end else if (m_p2 == WIN_SCORE) begin
                m_winner = 2;
                m_phase  = PH_OVER;
            end else begin
                m_ticks_seen = 0;
                m_recenter   = 1;
                m_phase      = PH_SERVE;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},    32'(state),           32'(m_phase));
        check({tag, ".recenter"}, 32'(paddle_recenter), 32'(m_recenter));
        check({tag, ".launch"},   32'(ball_launch),     32'(m_launch));
        check({tag, ".en"},       32'(paddle_en),       32'(m_phase == PH_PLAY));
        check({tag, ".dir"},      32'(serve_dir),       32'(m_dir));
        check({tag, ".score1"},   32'(score1),          32'(m_p1));
        check({tag, ".score2"},   32'(score2),          32'(m_p2));
        check({tag, ".winner"},   32'(winner),          32'(m_winner));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are checked
    // 1 time unit after the following rising edge.
    task automatic cycle(input bit st, input bit ft, input bit ml, input bit mr, input string tag);
        start_btn  = st;
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        model_edge(st, ft, ml, mr);
        #1;
        check_all(tag);
    endtask

    task automatic serve_ticks(input bit st, input string tag);
        for (int i = 0; i < SERVE_DELAY; i++) begin
            cycle(st, 1'b0, 1'b0, 1'b0, tag);
            cycle(st, 1'b1, 1'b0, 1'b0, tag);
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".asserted"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, "post_release");

        // Start, with a frame_tick on the entry edge that must not count.
        cycle(1, 1, 0, 0, "start");
        check("start.state_is_serve", 32'(state), 32'd1);
        check("start.recenter_pulse", 32'(paddle_recenter), 32'd1);
        cycle(0, 0, 0, 0, "start_after");
        check("start.recenter_done", 32'(paddle_recenter), 32'd0);
        cycle(0, 1, 0, 0, "tick1");
        cycle(0, 1, 0, 0, "tick2");
        check("tick2.still_serve", 32'(state), 32'd1);
        cycle(0, 1, 0, 0, "tick3");
        check("tick3.launch", 32'(ball_launch), 32'd1);
        check("tick3.play_en", 32'(paddle_en), 32'd1);
        cycle(0, 0, 0, 0, "launch_after");

        // Player 2 misses: point to player 1, serve toward right.
        cycle(0, 0, 0, 1, "miss_right");
        check("miss_right.score1", 32'(score1), 32'd1);
        check("miss_right.dir", 32'(serve_dir), 32'd1);
        cycle(0, 0, 0, 0, "point");
        check("point.recenter", 32'(paddle_recenter), 32'd1);
        serve_ticks(0, "reserve1");

        // Double miss is a let.
        cycle(0, 0, 1, 1, "let");
        check("let.dir_kept", 32'(serve_dir), 32'd1);
        cycle(0, 0, 0, 0, "let_point");
        // start held through serve/play, miss during serve ignored.
        cycle(1, 0, 1, 0, "serve_miss");
        cycle(1, 0, 0, 1, "serve_miss2");
        serve_ticks(1, "held_start");
        cycle(1, 0, 0, 0, "held_play");

        // Player 1 misses until player 2 wins.
        for (int k = 0; k < WIN_SCORE; k++) begin
            cycle(0, 0, 1, 0, "miss_left");
            cycle(0, 0, 0, 0, "miss_left_point");
            if (k < WIN_SCORE - 1) serve_ticks(0, "serve_left");
        end
        check("over.winner", 32'(winner), 32'd2);
        check("over.state", 32'(state), 32'd4);
        cycle(0, 1, 1, 0, "over_noise1");
        cycle(0, 1, 0, 1, "over_noise2");
        cycle(1, 0, 0, 0, "restart");
        check("restart.score2", 32'(score2), 32'd0);
        serve_ticks(0, "restart_serve");

        // Player 1 to three points, then reset mid-play.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, "p1_point");
            cycle(0, 0, 0, 0, "p1_point_done");
            serve_ticks(0, "p1_serve");
        end
        check("pre_reset.score1", 32'(score1), 32'd3);
        async_reset("mid_play");
        cycle(0, 0, 0, 0, "release1");
        cycle(0, 1, 0, 0, "release2");

        // Randomized play: start is rare, ticks and misses moderately common.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rand_rst");
            end else begin
                cycle(bit'($urandom_range(0, 15) == 0),
                      bit'($urandom_range(0, 2) == 0),
                      bit'($urandom_range(0, 9) == 0),
                      bit'($urandom_range(0, 9) == 0),
                      "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
